// File: rtl/digitizer_pkg.sv
// Shared definitions for the digitizer capture controller.
//   capture_state_t : capture FSM states
//   REG_*           : register offsets within the control block at 0x6000_0000
//   CTRL_*          : bit positions inside the control register
package digitizer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } capture_state_t;

    localparam logic [31:0] REG_CTRL     = 32'h0;
    localparam logic [31:0] REG_PKT_SIZE = 32'h8;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_CONT  = 1;

endpackage

// File: rtl/digitizer_capture_ctrl_packer.sv
// sample_packer: pairs consecutive valid ADC samples into one beat.
//   clk, reset     : fabric clock, synchronous active-high reset
//   i_clear        : synchronous clear; drops a half-collected pair
//   i_data/i_valid : incoming sample and qualifier
//   o_beat         : {second sample, first sample}
//   o_beat_strobe  : one-cycle pulse, registered, when o_beat is new
module sample_packer #(
    parameter int SAMPLE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic [SAMPLE_W-1:0]   i_data,
    input  logic                  i_valid,
    output logic [2*SAMPLE_W-1:0] o_beat,
    output logic                  o_beat_strobe
);

    logic [SAMPLE_W-1:0]   r_low;
    logic                  r_have_low;
    logic [2*SAMPLE_W-1:0] r_beat;
    logic                  r_strobe;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_have_low <= 1'b0;
            r_strobe   <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (i_valid) begin
                if (!r_have_low) begin
                    r_have_low <= 1'b1;
                end else begin
                    r_have_low <= 1'b0;
                    r_strobe   <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_low  <= '0;
            r_beat <= '0;
        end else if (!i_clear && i_valid) begin
            if (!r_have_low) r_low <= i_data;
            else             r_beat <= {i_data, r_low};
        end
    end

    assign o_beat        = r_beat;
    assign o_beat_strobe = r_strobe;

endmodule

// File: rtl/digitizer_capture_ctrl.sv
// digitizer_capture_ctrl: packs ADC samples into fixed-length AXI-Stream
// packets for the DMA S2MM channel.
//   cfg_start/cfg_continuous/cfg_stop/cfg_packet_bytes : software control
//   s_sample_data/s_sample_valid : ADC sample stream (cannot stall)
//   m_axis_*                     : AXI-Stream master towards the DMA
//   busy/done/cfg_error/overflow/overflow_count/packets_sent : status
module digitizer_capture_ctrl
    import digitizer_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int CNT_W    = 30,
    parameter int OVF_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic                  cfg_continuous,
    input  logic                  cfg_stop,
    input  logic [31:0]           cfg_packet_bytes,
    input  logic [SAMPLE_W-1:0]   s_sample_data,
    input  logic                  s_sample_valid,
    output logic [2*SAMPLE_W-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_error,
    output logic                  overflow,
    output logic [OVF_W-1:0]      overflow_count,
    output logic [31:0]           packets_sent
);

    capture_state_t        r_state, w_next_state;
    logic [CNT_W-1:0]      r_beats, r_beat_idx;
    logic [2*SAMPLE_W-1:0] r_tdata;
    logic                  r_tvalid, r_tlast, r_done;
    logic                  r_cfg_error, r_overflow, r_stop_pending;
    logic [OVF_W-1:0]      r_ovf_cnt;
    logic [31:0]           r_pkts;

    logic [2*SAMPLE_W-1:0] w_pk_beat;
    logic                  w_pk_strobe, w_pk_clear;
    logic [CNT_W-1:0]      w_size_beats;
    logic                  w_size_ok, w_handshake, w_last_idx;
    logic                  w_start_ok, w_start_bad, w_load, w_drop, w_pkt_end;

    assign w_size_beats = cfg_packet_bytes[CNT_W+1:2];
    assign w_size_ok    = (w_size_beats != '0) && (cfg_packet_bytes[1:0] == 2'b00);
    assign w_handshake  = r_tvalid && m_axis_tready;
    assign w_last_idx   = (r_beat_idx == r_beats - CNT_W'(1));

    // Holding the packer clear outside RUN discards samples seen in LAST/IDLE
    // and guarantees a re-armed packet starts on a fresh sample pair.
    assign w_pk_clear = (r_state != RUN);

    sample_packer #(.SAMPLE_W(SAMPLE_W)) u_packer (
        .clk           (clk),
        .reset         (reset),
        .i_clear       (w_pk_clear),
        .i_data        (s_sample_data),
        .i_valid       (s_sample_valid),
        .o_beat        (w_pk_beat),
        .o_beat_strobe (w_pk_strobe)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_start_ok   = 1'b0;
        w_start_bad  = 1'b0;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        w_pkt_end    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_start) begin
                    if (w_size_ok) begin
                        w_start_ok   = 1'b1;
                        w_next_state = RUN;
                    end else begin
                        w_start_bad = 1'b1;
                    end
                end
            end
            RUN: begin
                if (w_pk_strobe) begin
                    // Output register is free if empty or emptying this cycle.
                    if (!r_tvalid || m_axis_tready) begin
                        w_load = 1'b1;
                        if (w_last_idx) w_next_state = LAST;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            LAST: begin
                if (w_handshake) begin
                    w_pkt_end    = 1'b1;
                    w_next_state = (cfg_continuous && !r_stop_pending && !cfg_stop) ? RUN : IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beats        <= '0;
            r_beat_idx     <= '0;
            r_tdata        <= '0;
            r_tvalid       <= 1'b0;
            r_tlast        <= 1'b0;
            r_done         <= 1'b0;
            r_cfg_error    <= 1'b0;
            r_overflow     <= 1'b0;
            r_stop_pending <= 1'b0;
            r_ovf_cnt      <= '0;
            r_pkts         <= '0;
        end else begin
            r_done <= w_pkt_end;
            if (w_handshake) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
            if (w_load) begin
                r_tdata    <= w_pk_beat;
                r_tvalid   <= 1'b1;
                r_tlast    <= w_last_idx;
                r_beat_idx <= r_beat_idx + CNT_W'(1);
            end
            if (w_pkt_end) begin
                r_pkts     <= r_pkts + 32'd1;
                r_beat_idx <= '0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + OVF_W'(1);
            end
            if (w_start_bad) r_cfg_error <= 1'b1;
            if (w_start_ok) begin
                r_beats     <= w_size_beats;
                r_beat_idx  <= '0;
                r_cfg_error <= 1'b0;
                r_overflow  <= 1'b0;
                r_ovf_cnt   <= '0;
                r_pkts      <= '0;
            end
            if (w_next_state == IDLE)                 r_stop_pending <= 1'b0;
            else if (cfg_stop && r_state != IDLE)     r_stop_pending <= 1'b1;
        end
    end

    assign m_axis_tdata   = r_tdata;
    assign m_axis_tvalid  = r_tvalid;
    assign m_axis_tlast   = r_tlast;
    assign busy           = (r_state != IDLE);
    assign done           = r_done;
    assign cfg_error      = r_cfg_error;
    assign overflow       = r_overflow;
    assign overflow_count = r_ovf_cnt;
    assign packets_sent   = r_pkts;

endmodule

// File: tb/tb_digitizer_capture_ctrl.sv
module tb_digitizer_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_continuous = 1'b0;
    logic        cfg_stop = 1'b0;
    logic [31:0] cfg_packet_bytes = '0;
    logic [15:0] s_sample_data = '0;
    logic        s_sample_valid = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        busy, done, cfg_error, overflow;
    logic [15:0] overflow_count;
    logic [31:0] packets_sent;

    int checks = 0;
    int errors = 0;

    logic [32:0] q[$];          // {tlast, tdata} of every accepted beat
    int          done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    digitizer_capture_ctrl #(.SAMPLE_W(16), .CNT_W(30), .OVF_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_start        (cfg_start),
        .cfg_continuous   (cfg_continuous),
        .cfg_stop         (cfg_stop),
        .cfg_packet_bytes (cfg_packet_bytes),
        .s_sample_data    (s_sample_data),
        .s_sample_valid   (s_sample_valid),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .busy             (busy),
        .done             (done),
        .cfg_error        (cfg_error),
        .overflow         (overflow),
        .overflow_count   (overflow_count),
        .packets_sent     (packets_sent)
    );

    always #5 clk = ~clk;

    // Stream monitor: records handshakes, counts done pulses, and checks that a
    // stalled beat is held unchanged until accepted.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!(m_axis_tvalid && m_axis_tdata == prev_data && m_axis_tlast == prev_last)) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b d=%08h l=%0b, need v=1 d=%08h l=%0b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
                end
            end
            if (m_axis_tvalid && m_axis_tready) q.push_back({m_axis_tlast, m_axis_tdata});
            if (done) done_cnt++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, need %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        q.delete();
        done_cnt = 0;
    endtask

    task automatic start(input logic [31:0] bytes);
        cfg_packet_bytes = bytes;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic feed(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            s_sample_valid = 1'b1;
            s_sample_data  = 16'(base + i);
            tick();
        end
        s_sample_valid = 1'b0;
    endtask

    // Pairs separated by idle cycles so no sample falls into a LAST window.
    task automatic feed_pairs(input int npairs, input int base);
        for (int p = 0; p < npairs; p++) begin
            feed(2, base + 2 * p);
            repeat (3) tick();
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check(name, busy, 0);
        repeat (2) tick();
    endtask

    // Expect nbeats beats {base+2k+1, base+2k}, tlast every tl_every beats.
    task automatic check_beats(input string name, input int nbeats, input int base, input int tl_every);
        logic [15:0] lo, hi;
        check({name, "_count"}, q.size(), nbeats);
        for (int k = 0; k < nbeats && k < q.size(); k++) begin
            lo = 16'(base + 2 * k);
            hi = 16'(base + 2 * k + 1);
            check($sformatf("%s_data%0d", name, k), q[k][31:0], {hi, lo});
            check($sformatf("%s_last%0d", name, k), q[k][32], ((k + 1) % tl_every) == 0);
        end
    endtask

    typedef struct {
        logic [31:0] bytes;
        int          nsamp;
        logic        exp_err;
        int          exp_beats;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{bytes: 32'd16, nsamp: 8,  exp_err: 1'b0, exp_beats: 4};
        vecs[1] = '{bytes: 32'd6,  nsamp: 8,  exp_err: 1'b1, exp_beats: 0};
        vecs[2] = '{bytes: 32'd0,  nsamp: 8,  exp_err: 1'b1, exp_beats: 0};
        vecs[3] = '{bytes: 32'd3,  nsamp: 4,  exp_err: 1'b1, exp_beats: 0};
        vecs[4] = '{bytes: 32'd4,  nsamp: 2,  exp_err: 1'b0, exp_beats: 1};
        vecs[5] = '{bytes: 32'd4,  nsamp: 8,  exp_err: 1'b0, exp_beats: 1};
        vecs[6] = '{bytes: 32'd32, nsamp: 16, exp_err: 1'b0, exp_beats: 8};

        // Reset state
        do_reset();
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_error", cfg_error, 0);
        check("rst_overflow", overflow, 0);
        check("rst_ovf_cnt", overflow_count, 0);
        check("rst_pkts", packets_sent, 0);

        // Single-shot table: valid and invalid sizes
        for (int v = 0; v < 7; v++) begin
            do_reset();
            start(vecs[v].bytes);
            check($sformatf("v%0d_busy_start", v), busy, !vecs[v].exp_err);
            check($sformatf("v%0d_cfg_error", v), cfg_error, vecs[v].exp_err);
            feed(vecs[v].nsamp, 0);
            wait_idle($sformatf("v%0d_idle", v));
            check_beats($sformatf("v%0d", v), vecs[v].exp_beats, 0,
                        (vecs[v].exp_beats == 0) ? 1 : vecs[v].exp_beats);
            check($sformatf("v%0d_done", v), done_cnt, vecs[v].exp_err ? 0 : 1);
            check($sformatf("v%0d_pkts", v), packets_sent, vecs[v].exp_err ? 0 : 1);
            check($sformatf("v%0d_tvalid_end", v), m_axis_tvalid, 0);
        end

        // Continuous mode with stop in packet 3; invalid start then valid start
        do_reset();
        start(32'd6);
        check("cont_bad_err", cfg_error, 1);
        cfg_continuous = 1'b1;
        start(32'd8);
        check("cont_err_cleared", cfg_error, 0);
        check("cont_busy", busy, 1);
        feed_pairs(4, 0);
        check("cont_pkts2", packets_sent, 2);
        feed(2, 8);
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        check("cont_busy_after_stop", busy, 1);
        feed(2, 10);
        wait_idle("cont_idle");
        check_beats("cont", 6, 0, 2);
        check("cont_pkts", packets_sent, 3);
        check("cont_done", done_cnt, 3);
        feed_pairs(2, 12);
        check("cont_no_rearm", q.size(), 6);
        check("cont_busy_end", busy, 0);
        cfg_continuous = 1'b0;

        // Back-pressure: 6 beats form while stalled, 5 are dropped
        do_reset();
        start(32'd64);
        m_axis_tready = 1'b0;
        feed(12, 0);
        tick();
        check("bp_hold_valid", m_axis_tvalid, 1);
        check("bp_hold_data", m_axis_tdata, 32'h0001_0000);
        check("bp_ovf_cnt_stall", overflow_count, 5);
        start(32'd6);                       // ignored outside IDLE
        check("bp_start_ignored", cfg_error, 0);
        m_axis_tready = 1'b1;
        feed(30, 12);
        wait_idle("bp_idle");
        check("bp_count", q.size(), 16);
        if (q.size() == 16) begin
            check("bp_beat0", q[0], {1'b0, 32'h0001_0000});
            for (int j = 1; j < 16; j++)
                check($sformatf("bp_beat%0d", j), q[j],
                      {(j == 15), 16'(12 + 2 * (j - 1) + 1), 16'(12 + 2 * (j - 1))});
        end
        check("bp_overflow", overflow, 1);
        check("bp_ovf_cnt", overflow_count, 5);
        check("bp_pkts", packets_sent, 1);

        // Latency, then reset mid-packet and a fresh packet
        do_reset();
        start(32'd32);
        feed(2, 0);
        check("lat_not_yet", m_axis_tvalid, 0);
        s_sample_valid = 1'b1;
        s_sample_data  = 16'd2;
        tick();
        check("lat_valid", m_axis_tvalid, 1);
        check("lat_data", m_axis_tdata, 32'h0001_0000);
        feed(3, 3);
        repeat (2) tick();
        check("mid_beats", q.size(), 3);
        reset = 1'b1;
        tick();
        check("mid_rst_tvalid", m_axis_tvalid, 0);
        check("mid_rst_tdata", m_axis_tdata, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tlast", m_axis_tlast, 0);
        reset = 1'b0;
        q.delete();
        done_cnt = 0;
        start(32'd32);
        feed(16, 100);
        wait_idle("mid_idle");
        check_beats("mid", 8, 100, 8);
        check("mid_pkts", packets_sent, 1);

        // Full-rate throughput: 16384 beats
        do_reset();
        start(32'd65536);
        feed(32768, 0);
        wait_idle("thr_idle");
        check("thr_count", q.size(), 16384);
        begin
            int bad = 0;
            int lasts = 0;
            for (int k = 0; k < q.size(); k++) begin
                if (q[k][31:0] != {16'(2 * k + 1), 16'(2 * k)}) bad++;
                if (q[k][32]) lasts++;
            end
            check("thr_bad_data", bad, 0);
            check("thr_tlast_count", lasts, 1);
            if (q.size() > 0) check("thr_tlast_pos", q[q.size() - 1][32], 1);
        end
        check("thr_overflow", overflow, 0);
        check("thr_pkts", packets_sent, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
